// File: rtl/vr_fifo.sv
// ---------------------------------------------------------------------------
// vr_fifo -- synchronous valid/ready FIFO, single clock domain.
//
// Words offered by an upstream producer (s_*) are stored in a circular buffer
// and handed to a downstream consumer (m_*) in the order they were pushed.
// An empty FIFO shows a new word on m_* one cycle after it is pushed.
//
// Parameters
//   WIDTH  payload width in bits
//   DEPTH  number of storage entries (power of two, >= 2)
//
// Ports
//   clk      rising-edge clock
//   reset    synchronous active-high reset (clears pointers and occupancy)
//   s_valid  producer offers s_data
//   s_ready  FIFO has room; independent of m_ready
//   s_data   producer payload
//   m_valid  FIFO offers m_data
//   m_ready  consumer accepts m_data
//   m_data   head-of-queue payload
//   count    number of occupied entries (0..DEPTH)
//
// Build option
//   VR_FIFO_BYPASS_EN  when defined, an empty FIFO presents s_valid/s_data
//                      directly on m_valid/m_data. A word taken by the
//                      consumer in that same cycle never enters storage;
//                      otherwise it is stored as an ordinary push.
// ---------------------------------------------------------------------------
module vr_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [WIDTH-1:0]         s_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [WIDTH-1:0]         m_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  logic          empty, full;
  logic          push_en;   // word is written into storage this edge
  logic          pop_en;    // head entry is retired from storage this edge
  logic [DEPTH-1:0] wr_sel;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_COUNT);
  assign s_ready = !reset && !full;
  assign count   = count_q;

`ifdef VR_FIFO_BYPASS_EN
  // While empty, the producer's word is visible to the consumer immediately.
  // If the consumer takes it in that cycle it is delivered without touching
  // storage; if not, it is captured like any other push.
  assign m_valid = !reset && (!empty || s_valid);
  assign m_data  = empty ? s_data : mem_q[rd_ptr_q];
  assign push_en = s_valid && s_ready && !(empty && m_ready);
  assign pop_en  = m_valid && m_ready && !empty;
`else
  assign m_valid = !reset && !empty;
  assign m_data  = mem_q[rd_ptr_q];
  assign push_en = s_valid && s_ready;
  assign pop_en  = m_valid && m_ready;
`endif

  // Next-state for pointers and occupancy. DEPTH is a power of two, so the
  // natural AW-bit overflow of the pointers is the modulo-DEPTH wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // One-hot write select per storage entry.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
    assign wr_sel[gi] = push_en && (wr_ptr_q == AW'(gi));
  end

  // Storage is not reset: occupancy alone decides which entries are valid.
  // push_en is already low during reset because s_ready is forced low.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_sel[i]) begin
        mem_q[i] <= s_data;
      end
    end
  end

endmodule

// File: tb/tb_vr_fifo.sv
module tb_vr_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef VR_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic [CW-1:0]    count;

  vr_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .count   (count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the FIFO contents as a plain queue, plus a log of every
  // word the consumer has taken.
  logic [WIDTH-1:0] model_q [$];
  logic [WIDTH-1:0] rcv_q   [$];
  logic [WIDTH-1:0] sent_q  [$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, compare the DUT's
  // outputs with the model, then advance the model across the rising edge.
  task automatic step(input logic rst, input logic sv, input logic [WIDTH-1:0] sd,
                      input logic mr, input string tag);
    logic             exp_sr, exp_mv;
    logic [WIDTH-1:0] exp_md;
    int               sz;
    @(negedge clk);
    reset   = rst;
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
    #1;
    sz     = model_q.size();
    exp_sr = !rst && (sz < DEPTH);
    exp_mv = !rst && ((sz > 0) || (BYP && sv));
    exp_md = (sz > 0) ? model_q[0] : sd;
    check_eq({tag, ".s_ready"}, 32'(s_ready), 32'(exp_sr));
    check_eq({tag, ".m_valid"}, 32'(m_valid), 32'(exp_mv));
    check_eq({tag, ".count"},   32'(count),   32'(sz));
    if (exp_mv) check_eq({tag, ".m_data"}, 32'(m_data), 32'(exp_md));
    @(posedge clk);
    $display("txn %-6s rst=%0d sv=%0d sd=%02h mr=%0d | occ_before=%0d", tag, rst, sv, sd, mr, sz);
    if (rst) begin
      model_q.delete();
    end else begin
      if (exp_mv && mr) begin
        if (sz > 0) rcv_q.push_back(model_q.pop_front());
        else        rcv_q.push_back(sd);
      end
      if (sv && exp_sr && !(sz == 0 && exp_mv && mr)) model_q.push_back(sd);
    end
  endtask

  initial begin
    int src_idx, src_dly, snk_dly, cyc, prev_rcv;
    logic acc;
    logic [WIDTH-1:0] w;

    reset = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;

    // Reset behaviour.
    step(1'b1, 1'b0, 8'h00, 1'b0, "rst");
    step(1'b1, 1'b1, 8'h99, 1'b1, "rst");
    step(1'b0, 1'b0, 8'h00, 1'b0, "idle");
    check_eq("after_rst.s_ready", 32'(s_ready), 32'd1);
    check_eq("after_rst.m_valid", 32'(m_valid), 32'd0);

    // Fill with the sink stalled; the fifth word must be refused.
    for (int i = 1; i <= 5; i++) step(1'b0, 1'b1, 8'(i * 8'h11), 1'b0, "fill");
    step(1'b0, 1'b0, 8'h00, 1'b0, "idle");
    check_eq("fill.count",   32'(count),   32'd4);
    check_eq("fill.s_ready", 32'(s_ready), 32'd0);

    // Drain.
    rcv_q.delete();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h00, 1'b1, "drain");
    check_eq("drain.n", 32'(rcv_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < rcv_q.size(); i++)
      check_eq("drain.word", 32'(rcv_q[i]), 32'((i + 1) * 8'h11));
    #1;
    check_eq("drain.m_valid", 32'(m_valid), 32'd0);
    check_eq("drain.count",   32'(count),   32'd0);

    // Simultaneous push/pop at count=2 through several pointer wraps.
    rcv_q.delete();
    step(1'b0, 1'b1, 8'd1, 1'b0, "pre");
    step(1'b0, 1'b1, 8'd2, 1'b0, "pre");
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'(i + 3), 1'b1, "wrap");
    #1;
    check_eq("wrap.count", 32'(count), 32'd2);
    check_eq("wrap.n", 32'(rcv_q.size()), 32'd10);
    for (int i = 0; i < 10 && i < rcv_q.size(); i++)
      check_eq("wrap.word", 32'(rcv_q[i]), 32'(i + 1));

    // Reset mid-operation with three words stored.
    step(1'b1, 1'b0, 8'h00, 1'b0, "rst");
    step(1'b0, 1'b1, 8'h61, 1'b0, "fill3");
    step(1'b0, 1'b1, 8'h62, 1'b0, "fill3");
    step(1'b0, 1'b1, 8'h63, 1'b0, "fill3");
    step(1'b1, 1'b1, 8'h64, 1'b1, "rstmid");
    @(negedge clk);
    reset = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    #1;
    check_eq("rstmid.count",   32'(count),   32'd0);
    check_eq("rstmid.m_valid", 32'(m_valid), 32'd0);
    check_eq("rstmid.s_ready", 32'(s_ready), 32'd1);
    rcv_q.delete();
    step(1'b0, 1'b1, 8'hA5, 1'b0, "pushA5");
    step(1'b0, 1'b0, 8'h00, 1'b1, "popA5");
    check_eq("rstmid.n", 32'(rcv_q.size()), 32'd1);
    if (rcv_q.size() > 0) check_eq("rstmid.first", 32'(rcv_q[0]), 32'hA5);

`ifdef VR_FIFO_BYPASS_EN
    // Zero-latency pass-through from an empty FIFO.
    @(negedge clk);
    s_valid = 1'b1; s_data = 8'h3C; m_ready = 1'b1;
    #1;
    check_eq("byp.m_valid", 32'(m_valid), 32'd1);
    check_eq("byp.m_data",  32'(m_data),  32'h3C);
    check_eq("byp.count",   32'(count),   32'd0);
    @(posedge clk);
    $display("txn byp    sv=1 sd=3c mr=1");
    #1;
    s_valid = 1'b0; m_ready = 1'b0;
    check_eq("byp.count_after", 32'(count), 32'd0);
`else
    // Without bypass, a word pushed into an empty FIFO shows one cycle later.
    @(negedge clk);
    s_valid = 1'b1; s_data = 8'h3C; m_ready = 1'b1;
    #1;
    check_eq("lat.m_valid_same", 32'(m_valid), 32'd0);
    @(posedge clk);
    $display("txn lat    sv=1 sd=3c mr=1");
    #1;
    s_valid = 1'b0;
    check_eq("lat.m_valid_next", 32'(m_valid), 32'd1);
    check_eq("lat.m_data_next",  32'(m_data),  32'h3C);
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    check_eq("lat.count_after", 32'(count), 32'd0);
`endif

    // Randomised source/sink stalls, 100 words.
    void'($urandom(17));
    sent_q.delete();
    rcv_q.delete();
    for (int i = 0; i < 100; i++) sent_q.push_back(8'($urandom));
    src_idx = 0;
    src_dly = $urandom_range(0, 5);
    snk_dly = $urandom_range(0, 5);
    cyc     = 0;
    while (rcv_q.size() < 100 && cyc < 3000) begin
      w        = (src_idx < 100) ? sent_q[src_idx] : 8'h00;
      acc      = (src_idx < 100) && (src_dly == 0) && (model_q.size() < DEPTH);
      prev_rcv = rcv_q.size();
      step(1'b0, (src_idx < 100) && (src_dly == 0), w, snk_dly == 0, "rnd");
      if (acc) begin
        src_idx++;
        src_dly = $urandom_range(0, 5);
      end else if (src_dly > 0) begin
        src_dly--;
      end
      if (rcv_q.size() > prev_rcv) snk_dly = $urandom_range(0, 5);
      else if (snk_dly > 0)        snk_dly--;
      cyc++;
    end
    check_eq("rnd.n", 32'(rcv_q.size()), 32'd100);
    for (int i = 0; i < 100 && i < rcv_q.size(); i++)
      check_eq("rnd.word", 32'(rcv_q[i]), 32'(sent_q[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
